// File: rtl/mux_rr_sched.sv
// mux_rr_sched: round-robin scheduler that drives a shared 8:1 bit mux.
//
// Ports:
//   clk    - single clock; all state updates on its rising edge
//   rst    - synchronous, active-high reset
//   req    - request vector; requester i wants the mux when req[i]=1
//   din    - mux data; requester i owns din[i]
//   s      - registered mux select (index of the granted requester)
//   gnt    - registered one-hot grant; zero when no grant is active
//   y      - registered muxed data bit
//   y_vld  - y carries a transfer completed this cycle
//   busy   - high while a grant is active
//
// A grant lasts up to BURST_MAX transfers. It ends early as soon as the
// owner drops its request. Every release passes through IDLE for at least
// one cycle. Arbitration starts from the requester after the last owner.
module mux_rr_sched #(
   parameter int BURST_MAX = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] req,
   input  logic [7:0] din,
   output logic [2:0] s,
   output logic [7:0] gnt,
   output logic       y,
   output logic       y_vld,
   output logic       busy
);

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

   localparam logic [3:0] CNT_LAST = 4'(BURST_MAX - 1);

   state_t     state_q, state_d;
   logic [2:0] s_q, s_d;
   logic [7:0] gnt_q, gnt_d;
   logic       y_q, y_d;
   logic       y_vld_q, y_vld_d;
   logic [2:0] ptr_q, ptr_d;
   logic [3:0] cnt_q, cnt_d;

   // Requests rotated so that bit 0 is the requester at ptr. The lowest set
   // bit of this vector is then the round-robin winner.
   logic [7:0] req_rot;
   genvar gi;
   generate
      for (gi = 0; gi < 8; gi++) begin : g_rot
         assign req_rot[gi] = req[ptr_q + 3'(gi)];
      end
   endgenerate

   logic       found;
   logic [2:0] off;
   logic [2:0] pick;

   always_comb begin
      found = |req_rot;
      off   = 3'd0;
      // Scan downward so that the lowest set bit is the last one written.
      for (int k = 7; k >= 0; k--) begin
         if (req_rot[k]) begin
            off = 3'(k);
         end
      end
      pick = ptr_q + off;
   end

   always_comb begin
      state_d = state_q;
      s_d     = s_q;
      gnt_d   = gnt_q;
      y_d     = y_q;
      y_vld_d = 1'b0;
      ptr_d   = ptr_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            gnt_d = 8'd0;
            if (found) begin
               s_d     = pick;
               gnt_d   = 8'(1) << pick;
               cnt_d   = 4'd0;
               state_d = GRANT;
            end
         end
         GRANT: begin
            if (req[s_q]) begin
               y_d     = din[s_q];
               y_vld_d = 1'b1;
               cnt_d   = cnt_q + 4'd1;
               if (cnt_q == CNT_LAST) begin
                  state_d = IDLE;
                  gnt_d   = 8'd0;
                  ptr_d   = s_q + 3'd1;
               end
            end else begin
               // The owner withdrew, so release without a transfer.
               state_d = IDLE;
               gnt_d   = 8'd0;
               ptr_d   = s_q + 3'd1;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         s_q     <= 3'd0;
         gnt_q   <= 8'd0;
         y_q     <= 1'b0;
         y_vld_q <= 1'b0;
         ptr_q   <= 3'd0;
         cnt_q   <= 4'd0;
      end else begin
         state_q <= state_d;
         s_q     <= s_d;
         gnt_q   <= gnt_d;
         y_q     <= y_d;
         y_vld_q <= y_vld_d;
         ptr_q   <= ptr_d;
         cnt_q   <= cnt_d;
      end
   end

   assign s     = s_q;
   assign gnt   = gnt_q;
   assign y     = y_q;
   assign y_vld = y_vld_q;
   assign busy  = (state_q == GRANT);

endmodule

// File: tb/tb_mux_rr_sched.sv
// Testbench for mux_rr_sched: a BURST_MAX=4 instance and a BURST_MAX=1 instance.
// Each expected transfer (select, data bit) is queued before a scenario
// starts. A monitor pops one entry and compares it on every y_vld.
module tb_mux_rr_sched;

   typedef struct packed {
      logic [2:0] idx;
      logic       dbit;
   } xfer_t;

   logic       clk = 1'b0;
   logic       rst, rst1;
   logic [7:0] req, din, req1, din1;
   logic [2:0] s, s1;
   logic [7:0] gnt, gnt1;
   logic       y, y1, y_vld, y_vld1, busy, busy1;

   int    n_assert = 0;
   int    n_fail   = 0;
   bit    mon_en   = 1'b0;
   xfer_t q0[$];
   xfer_t q1[$];

   always #5 clk = ~clk;

   mux_rr_sched #(.BURST_MAX(4)) dut (
      .clk(clk), .rst(rst), .req(req), .din(din),
      .s(s), .gnt(gnt), .y(y), .y_vld(y_vld), .busy(busy)
   );

   mux_rr_sched #(.BURST_MAX(1)) dut1 (
      .clk(clk), .rst(rst1), .req(req1), .din(din1),
      .s(s1), .gnt(gnt1), .y(y1), .y_vld(y_vld1), .busy(busy1)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   // Scoreboard monitors and per-cycle invariants.
   always @(negedge clk) begin
      if (mon_en) begin
         xfer_t e;
         chk("busy_vs_gnt", 32'(busy), 32'(gnt != 8'd0));
         if (busy) chk("gnt_onehot", 32'(gnt), 32'(8'(1) << s));
         if (y_vld) begin
            if (q0.size() == 0) begin
               chk("xfer_unexpected", 32'(y_vld), 32'd0);
            end else begin
               e = q0.pop_front();
               chk("xfer_s", 32'(s), 32'(e.idx));
               chk("xfer_y", 32'(y), 32'(e.dbit));
            end
         end
         chk("busy1_vs_gnt1", 32'(busy1), 32'(gnt1 != 8'd0));
         if (y_vld1) begin
            if (q1.size() == 0) begin
               chk("xfer1_unexpected", 32'(y_vld1), 32'd0);
            end else begin
               e = q1.pop_front();
               chk("xfer1_s", 32'(s1), 32'(e.idx));
               chk("xfer1_y", 32'(y1), 32'(e.dbit));
            end
         end
      end
   end

   initial begin
      rst = 1'b1; rst1 = 1'b1;
      req = 8'd0; din = 8'd0; req1 = 8'd0; din1 = 8'd0;
      repeat (2) step();
      chk("rst_s", 32'(s), 32'd0);
      chk("rst_gnt", 32'(gnt), 32'd0);
      chk("rst_y", 32'(y), 32'd0);
      chk("rst_y_vld", 32'(y_vld), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      mon_en = 1'b1;
      rst = 1'b0;

      // Single persistent requester: 4 transfers, one IDLE cycle, regrant.
      din = 8'h01;
      for (int i = 0; i < 8; i++) q0.push_back('{3'd0, 1'b1});
      req = 8'h01;
      for (int g = 0; g < 2; g++) begin
         step();
         chk("s1_gnt", 32'(gnt), 32'h01);
         chk("s1_busy", 32'(busy), 32'd1);
         chk("s1_grant_vld", 32'(y_vld), 32'd0);
         for (int t = 0; t < 4; t++) begin
            step();
            chk("s1_vld", 32'(y_vld), 32'd1);
         end
         chk("s1_rel_gnt", 32'(gnt), 32'd0);
         chk("s1_rel_busy", 32'(busy), 32'd0);
      end
      req = 8'h00;
      step();
      chk("s1_idle_vld", 32'(y_vld), 32'd0);
      chk("s1_idle_gnt", 32'(gnt), 32'd0);
      chk("s1_idle_s", 32'(s), 32'd0);
      chk("s1_idle_y", 32'(y), 32'd1);

      // All requesting: order 0..7 then wrap to 0.
      rst = 1'b1; step(); rst = 1'b0;
      din = 8'hC5;
      for (int g = 0; g < 9; g++)
         for (int t = 0; t < 4; t++) q0.push_back('{3'(g % 8), din[g % 8]});
      req = 8'hFF;
      for (int g = 0; g < 9; g++) begin
         step();
         chk("s2_s", 32'(s), 32'(g % 8));
         chk("s2_gnt", 32'(gnt), 32'(8'(1) << (g % 8)));
         repeat (4) step();
      end
      req = 8'h00;
      step();

      // Owner drops its request after 2 transfers, so the grant is released early.
      rst = 1'b1; step(); rst = 1'b0;
      din = 8'h08;
      for (int t = 0; t < 2; t++) q0.push_back('{3'd3, 1'b1});
      for (int t = 0; t < 4; t++) q0.push_back('{3'd5, 1'b0});
      req = 8'h08;
      step();
      chk("s3_gnt3", 32'(gnt), 32'h08);
      repeat (2) step();
      req = 8'h23;
      step();
      chk("s3_drop_vld", 32'(y_vld), 32'd0);
      chk("s3_drop_gnt", 32'(gnt), 32'd0);
      chk("s3_drop_busy", 32'(busy), 32'd0);
      step();
      chk("s3_next_s", 32'(s), 32'd5);
      chk("s3_next_gnt", 32'(gnt), 32'h20);
      repeat (4) step();
      req = 8'h00;
      step();

      // din=A5 with req=24: a din[0] toggle must not disturb y.
      rst = 1'b1; step(); rst = 1'b0;
      din = 8'hA5;
      for (int t = 0; t < 4; t++) q0.push_back('{3'd2, 1'b1});
      for (int t = 0; t < 4; t++) q0.push_back('{3'd5, 1'b1});
      req = 8'h24;
      step();
      chk("s4_s2", 32'(s), 32'd2);
      for (int t = 0; t < 4; t++) begin din[0] = ~din[0]; step(); end
      step();
      chk("s4_s5", 32'(s), 32'd5);
      for (int t = 0; t < 4; t++) begin din[0] = ~din[0]; step(); end
      req = 8'h00;
      step();

      // Reset mid-grant (s=6, cnt=2); the next grant starts from ptr=0.
      rst = 1'b1; step(); rst = 1'b0;
      din = 8'h40;
      for (int t = 0; t < 2; t++) q0.push_back('{3'd6, 1'b1});
      req = 8'h40;
      step();
      chk("s5_s6", 32'(s), 32'd6);
      repeat (2) step();
      rst = 1'b1; req = 8'h41;
      step();
      chk("s5_rst_s", 32'(s), 32'd0);
      chk("s5_rst_gnt", 32'(gnt), 32'd0);
      chk("s5_rst_y", 32'(y), 32'd0);
      chk("s5_rst_vld", 32'(y_vld), 32'd0);
      chk("s5_rst_busy", 32'(busy), 32'd0);
      rst = 1'b0;
      step();
      chk("s5_regnt", 32'(gnt), 32'h01);
      chk("s5_regnt_s", 32'(s), 32'd0);
      req = 8'h00;
      step();
      chk("s5_nodrop_vld", 32'(y_vld), 32'd0);
      chk("s5_nodrop_gnt", 32'(gnt), 32'd0);

      // BURST_MAX=1: grants alternate 0,7,0,7 with one transfer each.
      rst1 = 1'b0;
      din1 = 8'h80;
      for (int g = 0; g < 4; g++) q1.push_back('{(g % 2 == 1) ? 3'd7 : 3'd0, (g % 2 == 1)});
      req1 = 8'h81;
      for (int g = 0; g < 4; g++) begin
         step();
         chk("s6_gnt", 32'(gnt1), (g % 2 == 1) ? 32'h80 : 32'h01);
         chk("s6_grant_vld", 32'(y_vld1), 32'd0);
         step();
         chk("s6_vld", 32'(y_vld1), 32'd1);
         chk("s6_rel_gnt", 32'(gnt1), 32'd0);
      end
      req1 = 8'h00;
      step();

      chk("q0_drained", 32'(q0.size()), 32'd0);
      chk("q1_drained", 32'(q1.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
